// File: rtl/ddr_motor_controller.sv
// Step/direction pulse generator for one stepper axis. Periods come from an upstream FWFT FIFO
// (per-step profile) or a single programmed value; position and active period are reported.
module ddr_motor_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pul_rst,
  input  logic [1:0]  pul_mode,
  input  logic        pul_stop,
  input  logic [31:0] step,
  input  logic [15:0] accel_end,
  input  logic [15:0] decel_begin,
  input  logic [31:0] pul_value,
  input  logic        pul_dir,
  input  logic        pos_clr,
  output logic        pul_out,
  output logic        read,
  output logic [31:0] step_pos,
  output logic [31:0] step_speed
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  localparam logic [1:0] ModeConst   = 2'b00;
  localparam logic [1:0] ModeProfile = 2'b01;
  localparam logic [1:0] ModeJog     = 2'b10;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [31:0] step_q, step_d;
  logic [15:0] accel_q, accel_d;
  logic [15:0] decel_q, decel_d;
  logic [1:0]  mode_q, mode_d;
  logic        dir_q, dir_d;
  logic [31:0] period_q, period_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] k_q, k_d;
  logic        stop_q, stop_d;
  logic [31:0] pos_q, pos_d;
  logic [31:0] speed_q, speed_d;
  logic        pul_q, pul_d;

  logic [31:0] clamped;
  logic [31:0] k_next;
  logic        period_end;
  logic        stop_req;
  logic        finish;
  logic        in_window;

  always_comb begin
    clamped    = (pul_value < 32'd2) ? 32'd2 : pul_value;
    k_next     = k_q + 32'd1;
    period_end = (cnt_q == period_q - 32'd1);
    stop_req   = pul_stop | ~en;
    finish     = ((mode_q != ModeJog) && (k_next == step_q)) || stop_q || stop_req;
    // Overlapping or adjacent windows make every step a read.
    in_window  = (k_next <= {16'd0, accel_q}) || (k_next >= {16'd0, decel_q});
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en;
    step_d   = step_q;
    accel_d  = accel_q;
    decel_d  = decel_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    stop_d   = stop_q;
    pos_d    = pos_q;
    speed_d  = speed_q;
    read     = 1'b0;
    pul_d    = (state_q == StRun) && (cnt_q < (period_q >> 1));

    if (state_q == StRun && cnt_q == 32'd0) begin
      pos_d = dir_q ? pos_q - 32'd1 : pos_q + 32'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (en && !en_q) begin
          step_d  = step;
          accel_d = accel_end;
          decel_d = decel_begin;
          mode_d  = (pul_mode == 2'b11) ? ModeConst : pul_mode;
          dir_d   = pul_dir;
          if (pul_mode == ModeJog || step != 32'd0) begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        read     = 1'b1;
        period_d = clamped;
        speed_d  = clamped;
        k_d      = 32'd0;
        cnt_d    = 32'd0;
        stop_d   = 1'b0;
        state_d  = StRun;
      end
      StRun: begin
        if (stop_req) begin
          stop_d = 1'b1;
        end
        if (period_end) begin
          if (finish) begin
            state_d = StIdle;
            stop_d  = 1'b0;
          end else begin
            k_d   = k_next;
            cnt_d = 32'd0;
            if (mode_q == ModeProfile && in_window) begin
              read     = 1'b1;
              period_d = clamped;
              speed_d  = clamped;
            end
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Soft reset freezes position but abandons the move.
    if (pul_rst) begin
      state_d = StIdle;
      pul_d   = 1'b0;
      read    = 1'b0;
      speed_d = 32'd0;
      stop_d  = 1'b0;
      pos_d   = pos_q;
    end

    if (pos_clr) begin
      pos_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      // Held high so a level-high en after reset cannot start a move without a fresh edge.
      en_q     <= 1'b1;
      step_q   <= 32'd0;
      accel_q  <= 16'd0;
      decel_q  <= 16'd0;
      mode_q   <= ModeConst;
      dir_q    <= 1'b0;
      period_q <= 32'd2;
      cnt_q    <= 32'd0;
      k_q      <= 32'd0;
      stop_q   <= 1'b0;
      pos_q    <= 32'd0;
      speed_q  <= 32'd0;
      pul_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      step_q   <= step_d;
      accel_q  <= accel_d;
      decel_q  <= decel_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      stop_q   <= stop_d;
      pos_q    <= pos_d;
      speed_q  <= speed_d;
      pul_q    <= pul_d;
    end
  end

  assign pul_out    = pul_q;
  assign step_pos   = pos_q;
  assign step_speed = speed_q;

endmodule

// File: tb/tb_ddr_motor_controller.sv
// Self-checking bench for ddr_motor_controller: behavioural move model checked every cycle,
// directed scenarios with hand-computed totals, then randomized moves.
module tb_ddr_motor_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        pul_rst = 1'b0;
  logic [1:0]  pul_mode = 2'b00;
  logic        pul_stop = 1'b0;
  logic [31:0] step = 32'd0;
  logic [15:0] accel_end = 16'd0;
  logic [15:0] decel_begin = 16'd0;
  logic [31:0] pul_value;
  logic        pul_dir = 1'b0;
  logic        pos_clr = 1'b0;
  logic        pul_out;
  logic        read;
  logic [31:0] step_pos;
  logic [31:0] step_speed;

  int n_checks = 0;
  int n_err = 0;
  int n_rise = 0;
  int n_high = 0;
  int n_read = 0;
  logic prev_pul = 1'b0;

  // Upstream FIFO emulation: 0 = free-running value, 1 = linear ramp, 2 = table.
  int          fifo_kind = 0;
  logic [31:0] fifo_idx = 32'd0;
  logic [31:0] fifo_start = 32'd0;
  logic [31:0] pv_rand = 32'd5;
  int unsigned prof_tbl [0:11] = '{40, 30, 20, 15, 12, 10, 8, 6, 5, 4, 3, 3};

  function automatic logic [31:0] fifo_val(input logic [31:0] i);
    if (fifo_kind == 1) return 32'd10 + 32'd2 * i;
    if (i > 32'd11) return 32'd3;
    return prof_tbl[i];
  endfunction

  assign pul_value = (fifo_kind == 0) ? pv_rand : fifo_val(fifo_idx - fifo_start);

  always @(posedge clk) begin
    if (rst && read) fifo_idx <= fifo_idx + 32'd1;
  end

  ddr_motor_controller dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pul_rst    (pul_rst),
    .pul_mode   (pul_mode),
    .pul_stop   (pul_stop),
    .step       (step),
    .accel_end  (accel_end),
    .decel_begin(decel_begin),
    .pul_value  (pul_value),
    .pul_dir    (pul_dir),
    .pos_clr    (pos_clr),
    .pul_out    (pul_out),
    .read       (read),
    .step_pos   (step_pos),
    .step_speed (step_speed)
  );

  always #5 clk = ~clk;

  // Reference: a move is "idle / loading / running", with position t inside the current
  // period per, step number k, and the rule set for ending, reading and pulsing.
  typedef struct {
    int          phase;  // 0 idle, 1 loading first period, 2 running
    logic [31:0] per;
    logic [31:0] t;
    logic [31:0] k;
    logic [31:0] steps;
    logic [15:0] a;
    logic [15:0] d;
    bit          jog;
    bit          prof;
    bit          down;
    bit          stop;
    bit          prev_en;
    bit          pulse;
    logic [31:0] pos;
    logic [31:0] speed;
  } model_t;

  model_t m;

  function automatic model_t reset_model();
    model_t r;
    r.phase = 0; r.per = 32'd2; r.t = 0; r.k = 0; r.steps = 0; r.a = 0; r.d = 0;
    r.jog = 0; r.prof = 0; r.down = 0; r.stop = 0; r.prev_en = 1; r.pulse = 0;
    r.pos = 0; r.speed = 0;
    return r;
  endfunction

  function automatic bit ends_now(input model_t c);
    return (!c.jog && c.k + 32'd1 == c.steps) || c.stop || pul_stop || !en;
  endfunction

  function automatic bit reads_at_end(input model_t c);
    logic [31:0] nk;
    nk = c.k + 32'd1;
    return c.prof && (nk <= {16'd0, c.a} || nk >= {16'd0, c.d});
  endfunction

  function automatic bit exp_read(input model_t c);
    if (pul_rst) return 1'b0;
    if (c.phase == 1) return 1'b1;
    if (c.phase == 2 && c.t == c.per - 32'd1 && !ends_now(c) && reads_at_end(c)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic model_t model_next(input model_t c);
    model_t      n;
    logic [31:0] pv2;
    n = c;
    pv2 = (pul_value < 32'd2) ? 32'd2 : pul_value;
    n.prev_en = en;
    if (pul_rst) begin
      n.phase = 0; n.pulse = 0; n.speed = 0; n.stop = 0;
    end else begin
      n.pulse = (c.phase == 2) && (c.t < c.per / 32'd2);
      if (c.phase == 2 && c.t == 0) n.pos = c.down ? c.pos - 32'd1 : c.pos + 32'd1;
      if (c.phase == 0) begin
        if (en && !c.prev_en) begin
          n.steps = step; n.a = accel_end; n.d = decel_begin; n.down = pul_dir;
          n.jog = (pul_mode == 2'b10);
          n.prof = (pul_mode == 2'b01);
          if (n.jog || step != 0) n.phase = 1;
        end
      end else if (c.phase == 1) begin
        n.per = pv2; n.speed = pv2; n.k = 0; n.t = 0; n.stop = 0; n.phase = 2;
      end else begin
        if (pul_stop || !en) n.stop = 1;
        if (c.t == c.per - 32'd1) begin
          if (ends_now(c)) begin
            n.phase = 0; n.stop = 0;
          end else begin
            n.k = c.k + 32'd1;
            n.t = 0;
            if (reads_at_end(c)) begin
              n.per = pv2; n.speed = pv2;
            end
          end
        end else begin
          n.t = c.t + 32'd1;
        end
      end
    end
    if (pos_clr) n.pos = 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= reset_model();
    else      m <= model_next(m);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("pul_out", {31'd0, pul_out}, {31'd0, m.pulse});
      check("read", {31'd0, read}, {31'd0, exp_read(m)});
      check("step_pos", step_pos, m.pos);
      check("step_speed", step_speed, m.speed);
      if (pul_out && !prev_pul) n_rise++;
      if (pul_out) n_high++;
      if (read) n_read++;
    end
    prev_pul <= pul_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_move(input int mode, input int steps, input int a, input int d,
                            input int dir);
    en = 1'b0;
    pul_stop = 1'b0;
    tick();
    pul_mode = 2'(mode);
    step = 32'(steps);
    accel_end = 16'(a);
    decel_begin = 16'(d);
    pul_dir = 1'(dir);
    en = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (m.phase != 0 && cycles < budget) begin
      tick();
      cycles++;
    end
    if (m.phase != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic clear_pos();
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
  endtask

  int r0, h0, s0, cyc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_pul_out", {31'd0, pul_out}, 32'd0);
    check("reset_read", {31'd0, read}, 32'd0);
    check("reset_step_pos", step_pos, 32'd0);
    check("reset_step_speed", step_speed, 32'd0);
    rst = 1'b1;
    tick();

    // Linear FIFO ramp, all steps inside the read windows.
    fifo_kind = 1;
    fifo_start = fifo_idx;
    clear_pos();
    r0 = n_read;
    start_move(1, 50, 24, 25, 0);
    wait_idle(5000, cyc);
    check("ramp_reads", 32'(n_read - r0), 32'd50);
    check("ramp_len", 32'(cyc), 32'd2951);
    check("ramp_pos", step_pos, 32'd50);
    check("ramp_speed", step_speed, 32'd108);

    // Accel 0..2, cruise 3..6, decel 7..9.
    fifo_kind = 2;
    fifo_start = fifo_idx;
    clear_pos();
    r0 = n_read;
    start_move(1, 10, 2, 7, 0);
    wait_idle(1000, cyc);
    check("prof_reads", 32'(n_read - r0), 32'd6);
    check("prof_len", 32'(cyc), 32'd208);
    check("prof_pos", step_pos, 32'd10);
    check("prof_speed", step_speed, 32'd10);

    // Constant speed, counting down.
    fifo_kind = 0;
    pv_rand = 32'd7;
    clear_pos();
    r0 = n_read; h0 = n_high; s0 = n_rise;
    start_move(0, 4, 0, 0, 1);
    wait_idle(200, cyc);
    tick();
    check("const_reads", 32'(n_read - r0), 32'd1);
    check("const_rises", 32'(n_rise - s0), 32'd4);
    check("const_highs", 32'(n_high - h0), 32'd12);
    check("const_pos", step_pos, 32'hFFFF_FFFC);

    // Jog with clamped period, stopped mid-move.
    pv_rand = 32'd1;
    r0 = n_read; s0 = n_rise;
    start_move(2, 0, 0, 0, 0);
    cyc = 0;
    while (n_rise - s0 < 3 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("jog_running", 32'(n_rise - s0 >= 3), 32'd1);
    check("jog_speed", step_speed, 32'd2);
    pul_stop = 1'b1;
    tick();
    pul_stop = 1'b0;
    wait_idle(20, cyc);
    s0 = n_rise;
    repeat (10) tick();
    check("jog_no_more_rises", 32'(n_rise - s0), 32'd0);
    check("jog_reads", 32'(n_read - r0), 32'd1);

    // pos_clr on the cnt=0 cycle discards that step's increment.
    pv_rand = 32'd5;
    clear_pos();
    start_move(0, 3, 0, 0, 0);
    tick();
    pos_clr = 1'b1;
    tick();
    pos_clr = 1'b0;
    check("posclr_pos", step_pos, 32'd0);
    wait_idle(100, cyc);
    check("posclr_final", step_pos, 32'd2);

    // Soft reset mid-move keeps position.
    pv_rand = 32'd6;
    r0 = n_read;
    start_move(0, 8, 0, 0, 0);
    repeat (8) tick();
    pul_rst = 1'b1;
    tick();
    pul_rst = 1'b0;
    check("pulrst_pul_out", {31'd0, pul_out}, 32'd0);
    check("pulrst_speed", step_speed, 32'd0);
    check("pulrst_pos", step_pos, 32'd4);
    s0 = n_rise;
    repeat (10) tick();
    check("pulrst_quiet", 32'(n_rise - s0), 32'd0);
    check("pulrst_reads", 32'(n_read - r0), 32'd1);

    // Asynchronous reset mid-move, en left high.
    pv_rand = 32'd4;
    start_move(0, 20, 0, 0, 0);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_pul_out", {31'd0, pul_out}, 32'd0);
    check("arst_read", {31'd0, read}, 32'd0);
    check("arst_pos", step_pos, 32'd0);
    check("arst_speed", step_speed, 32'd0);
    tick();
    rst = 1'b1;
    r0 = n_read; s0 = n_rise;
    repeat (10) tick();
    check("arst_no_restart", 32'(n_read - r0 + n_rise - s0), 32'd0);

    // Zero-length move.
    r0 = n_read; s0 = n_rise;
    start_move(0, 0, 0, 0, 0);
    repeat (10) tick();
    check("zero_reads", 32'(n_read - r0), 32'd0);
    check("zero_rises", 32'(n_rise - s0), 32'd0);

    // Randomized moves against the model.
    for (int mv = 0; mv < 30; mv++) begin
      start_move(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 6)), int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 1)));
      for (int c = 0; c < 400 && (m.phase != 0 || c < 3); c++) begin
        pv_rand = $urandom_range(0, 12);
        pul_stop = ($urandom_range(0, 59) == 0) || (c > 200);
        en = en && ($urandom_range(0, 79) != 0);
        pul_rst = ($urandom_range(0, 149) == 0);
        pos_clr = ($urandom_range(0, 99) == 0);
        step = $urandom;
        accel_end = 16'($urandom);
        decel_begin = 16'($urandom);
        pul_dir = 1'($urandom_range(0, 1));
        tick();
      end
      pul_stop = 1'b0;
      pul_rst = 1'b0;
      pos_clr = 1'b0;
    end
    en = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
